elastic_pipe: RTL and testbench

ELASTIC_PIPE -- requirements
Module: elastic_pipe

---
 rtl/elastic_pipe_pkg.sv | 13 +
 rtl/elastic_pipe_stage.sv | 46 ++++
 rtl/elastic_pipe.sv | 106 ++++++++++
 tb/tb_elastic_pipe.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/elastic_pipe_pkg.sv
// Shared constants and helpers for the elastic pipeline.
// Optional flush port is enabled by defining ELASTIC_PIPE_FLUSH_EN.
package elastic_pipe_pkg;

  localparam int EP_WIDTH_DEF = 8;
  localparam int EP_DEPTH_DEF = 4;

  // Bits needed to count 0..depth valid stages.
  function automatic int ep_count_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/elastic_pipe_stage.sv
// One pipeline stage: a valid bit and a data register, both cleared asynchronously.
// clear_i drops the valid bit only; the data register keeps its contents.
module elastic_pipe_stage
  import elastic_pipe_pkg::*;
#(
  parameter int WIDTH = EP_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic             up_valid_i,
  input  logic [WIDTH-1:0] up_data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = up_valid_i;
      // A bubble moving in leaves the old payload in place.
      if (up_valid_i) data_d = up_data_i;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/elastic_pipe.sv
// DEPTH-stage elastic pipeline with bubble collapsing and a valid-stage counter.
// Define ELASTIC_PIPE_FLUSH_EN to add the synchronous flush input.
//
// Handshake: a word transfers on a rising edge when valid and ready are both 1
// in the preceding cycle; valid never waits on ready, and in_ready never looks
// at in_valid.
module elastic_pipe
  import elastic_pipe_pkg::*;
#(
  parameter int WIDTH = EP_WIDTH_DEF,
  parameter int DEPTH = EP_DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rstn,
`ifdef ELASTIC_PIPE_FLUSH_EN
  input  logic                         flush,
`endif
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [ep_count_w(DEPTH)-1:0] count
);

  localparam int CW = ep_count_w(DEPTH);
  localparam logic [DEPTH-1:0] ALL_ONES = {DEPTH{1'b1}};

  logic             flush_w;
  logic [DEPTH-1:0] v_w;
  logic [DEPTH-1:0] rdy_w;
  logic [WIDTH-1:0] d_w [DEPTH];
  logic             in_fire, out_fire;
  logic [CW-1:0]    count_q, count_d;

`ifdef ELASTIC_PIPE_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // Closed form of the ready chain: stage i is ready unless every stage from
  // i to the output is occupied and the output is stalled.
  always_comb begin
    rdy_w = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rdy_w[i] = out_ready || ((v_w >> i) != (ALL_ONES >> i));
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic             up_v;
    logic [WIDTH-1:0] up_d;

    if (g == 0) begin : g_first
      assign up_v = in_valid;
      assign up_d = in_data;
    end else begin : g_rest
      assign up_v = v_w[g-1];
      assign up_d = d_w[g-1];
    end

    elastic_pipe_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk       (clk),
      .rstn      (rstn),
      .load_i    (rdy_w[g]),
      .clear_i   (flush_w),
      .up_valid_i(up_v),
      .up_data_i (up_d),
      .valid_o   (v_w[g]),
      .data_o    (d_w[g])
    );
  end

  assign in_ready  = rdy_w[0] && !flush_w;
  assign out_valid = v_w[DEPTH-1] && !flush_w;
  assign out_data  = d_w[DEPTH-1];

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Shifts only move valid bits between stages, so the popcount of the next
  // valid vector differs from the current one by entries minus exits.
  always_comb begin
    count_d = count_q;
    if (flush_w) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(in_fire) - CW'(out_fire);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_elastic_pipe.sv
// Directed bench for elastic_pipe (WIDTH=8, DEPTH=4) with an in-order scoreboard.
// Flush scenario runs only when ELASTIC_PIPE_FLUSH_EN is defined.
module tb_elastic_pipe;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       count;
`ifdef ELASTIC_PIPE_FLUSH_EN
  logic             flush = 1'b0;
`endif

  int n_checks = 0;
  int n_errs   = 0;
  logic [WIDTH-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  elastic_pipe #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
`ifdef ELASTIC_PIPE_FLUSH_EN
    .flush    (flush),
`endif
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .count    (count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_stalled(input logic [WIDTH-1:0] d);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = d;
    #1;
    check("fill_in_ready", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
  endtask

  // scoreboard: inputs are stable from posedge+2 until the next posedge
  always @(negedge clk) begin
    if (rstn) begin
      if (in_valid && in_ready) exp_q.push_back(in_data);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 1);
        else check("sb_order", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int n;
    // reset state while rstn is low
    #3;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_count", 32'(count), 0);
    #9 rstn = 1'b1;
    step();
    check("post_rst_in_ready", 32'(in_ready), 1);

    // single word latency into an empty pipe
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h11;
    #1;
    check("lat_in_ready", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
    check("lat_count1", 32'(count), 1);
    for (int k = 1; k < DEPTH; k++) begin
      check("lat_early", 32'(out_valid), 0);
      step();
    end
    check("lat_out_valid", 32'(out_valid), 1);
    check("lat_out_data", 32'(out_data), 32'h11);
    step();
    check("lat_gone", 32'(out_valid), 0);
    check("lat_count0", 32'(count), 0);

    // fill under stall, then drain in order
    for (int k = 1; k <= 4; k++) push_stalled(8'(k));
    in_valid = 1'b1;
    in_data  = 8'h05;
    #1;
    check("full_in_ready", 32'(in_ready), 0);
    check("full_count", 32'(count), 4);
    step();
    step();
    check("stall_out_valid", 32'(out_valid), 1);
    check("stall_out_data", 32'(out_data), 1);
    check("stall_count", 32'(count), 4);
    out_ready = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      in_valid = (j <= 2);
      in_data  = 8'(4 + j);
      #1;
      check("drain_valid", 32'(out_valid), 1);
      check("drain_data", 32'(out_data), 32'(j));
      step();
    end
    in_valid = 1'b0;
    check("drain_count", 32'(count), 0);

    // full pipe streaming at one word per cycle
    for (int k = 0; k < 4; k++) push_stalled(8'(8'h20 + k));
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h30 + k);
      #1;
      check("stream_count", 32'(count), 4);
      check("stream_in_ready", 32'(in_ready), 1);
      check("stream_out_valid", 32'(out_valid), 1);
      check("stream_out_data", 32'(out_data), (k < 4) ? 32'(8'h20 + k) : 32'(8'h30 + k - 4));
      step();
    end
    in_valid = 1'b0;
    n = 0;
    while (count != 0 && n < 20) begin
      step();
      n++;
    end
    check("stream_drained", 32'(count), 0);

    // bubble between A0 and A1 collapses under an output stall
    push_stalled(8'hA0);
    step();
    push_stalled(8'hA1);
    n = 0;
    while (!out_valid && n < 10) begin
      step();
      n++;
    end
    check("bub_arrive", 32'(out_valid), 1);
    for (int k = 0; k < 3; k++) begin
      check("bub_count", 32'(count), 2);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("bub_first", 32'(out_data), 32'hA0);
    step();
    check("bub_second_valid", 32'(out_valid), 1);
    check("bub_second", 32'(out_data), 32'hA1);
    step();
    check("bub_empty", 32'(out_valid), 0);

    // asynchronous reset mid-stream
    for (int k = 1; k <= 3; k++) push_stalled(8'(8'h50 + k));
    check("mid_count3", 32'(count), 3);
    #1 rstn = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_count", 32'(count), 0);
    check("mid_rst_data", 32'(out_data), 0);
    @(negedge clk);
    #1 rstn = 1'b1;
    step();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h5A;
    #1;
    check("mid_in_ready", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
    for (int k = 1; k < DEPTH; k++) begin
      check("mid_no_stale", 32'(out_valid), 0);
      step();
    end
    check("mid_word_valid", 32'(out_valid), 1);
    check("mid_word_data", 32'(out_data), 32'h5A);
    step();
    check("mid_alone", 32'(out_valid), 0);

`ifdef ELASTIC_PIPE_FLUSH_EN
    // flush of a full pipe beats simultaneous handshakes
    for (int k = 0; k < 4; k++) push_stalled(8'(8'hC0 + k));
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hCC;
    flush     = 1'b1;
    #1;
    check("flush_in_ready", 32'(in_ready), 0);
    check("flush_out_valid", 32'(out_valid), 0);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    #1;
    check("flush_count", 32'(count), 0);
    check("flush_after_valid", 32'(out_valid), 0);
    check("flush_after_ready", 32'(in_ready), 1);
`endif

    step();
    check("sb_leftover", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
